// File: rtl/ctu_clsp_cmpgen.sv
// CMP-domain clock sequencer: starts the clock, walks the per-unit clock
// enables one gap at a time, releases global reset, then generates jbus/dram sync pulses.
module ctu_clsp_cmpgen #(
    parameter int CKEN_GAP = 4,
    parameter int RST_DLY  = 16,
    parameter int DBG_LEN  = 8
) (
    input  logic        cmp_gclk,
    input  logic        io_pwron_rst_l,
    input  logic        clk_seq_go,
    input  logic [21:0] cken_en_mask,
    input  logic [3:0]  jbus_ratio,
    input  logic [3:0]  dram_ratio,
    input  logic        dbginit_req,
    output logic        start_clk_cl,
    output logic        cmp_grst_cl_l,
    output logic        cmp_dbginit_cl_l,
    output logic        ctu_jbus_tx_sync_cl,
    output logic        ctu_jbus_rx_sync_cl,
    output logic        ctu_dram_tx_sync_cl,
    output logic        ctu_dram_rx_sync_cl,
    output logic [21:0] cken_cg,
    output logic        seq_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] CKEN  = 3'd2;
    localparam logic [2:0] RSTW  = 3'd3;
    localparam logic [2:0] RUN   = 3'd4;

    localparam logic [15:0] GAP_M1 = 16'(CKEN_GAP - 1);
    localparam logic [15:0] RST_M1 = 16'(RST_DLY - 1);
    localparam logic [15:0] DBG_M1 = 16'(DBG_LEN - 1);
    localparam logic [4:0]  IDX_LAST = 5'd21;

    logic [2:0]  state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [4:0]  idx, idx_nx, idx_p1;
    logic [15:0] dbg_cnt, dbg_cnt_nx;
    logic [3:0]  jcnt, jcnt_nx, jr, jr_nx;
    logic [3:0]  dcnt, dcnt_nx, dr, dr_nx;
    logic        start_nx, grst_nx, dbg_nx, done_nx;
    logic        jtx_nx, jrx_nx, dtx_nx, drx_nx;
    logic [21:0] cken_nx;

    // Ratios below 2 cannot produce distinct tx/rx cycles, so they run as 2.
    function automatic logic [3:0] eff_ratio(input logic [3:0] r);
        return (r < 4'd2) ? 4'd2 : r;
    endfunction

    assign idx_p1 = idx + 5'd1;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        dbg_cnt_nx = dbg_cnt;
        start_nx   = start_clk_cl;
        grst_nx    = cmp_grst_cl_l;
        dbg_nx     = cmp_dbginit_cl_l;
        cken_nx    = cken_cg;
        done_nx    = seq_done;
        jcnt_nx    = jcnt;
        jr_nx      = jr;
        dcnt_nx    = dcnt;
        dr_nx      = dr;

        if (state != IDLE && !clk_seq_go) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            idx_nx     = '0;
            dbg_cnt_nx = '0;
            start_nx   = 1'b0;
            grst_nx    = 1'b0;
            dbg_nx     = 1'b0;
            cken_nx    = '0;
            done_nx    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clk_seq_go) begin
                        state_nx = START;
                        cnt_nx   = '0;
                        start_nx = 1'b1;
                    end
                end
                START: begin
                    if (cnt == GAP_M1) begin
                        state_nx   = CKEN;
                        cnt_nx     = '0;
                        idx_nx     = '0;
                        cken_nx[0] = cken_en_mask[0];
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                CKEN: begin
                    // idx names the bit most recently enabled; the last one hands off to RSTW.
                    if (cnt == GAP_M1) begin
                        cnt_nx          = '0;
                        idx_nx          = idx_p1;
                        cken_nx[idx_p1] = cken_en_mask[idx_p1];
                        if (idx_p1 == IDX_LAST) begin
                            state_nx = RSTW;
                        end
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                RSTW: begin
                    if (cnt == RST_M1) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                        grst_nx  = 1'b1;
                        dbg_nx   = 1'b1;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                RUN: begin
                    cken_nx = cken_en_mask;
                    if (!cmp_dbginit_cl_l) begin
                        if (dbg_cnt == '0) begin
                            dbg_nx = 1'b1;
                        end else begin
                            dbg_cnt_nx = dbg_cnt - 16'd1;
                        end
                    end else if (dbginit_req) begin
                        dbg_nx     = 1'b0;
                        dbg_cnt_nx = DBG_M1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        // Sync counters run off the registered clock-start; the period ratio
        // is re-latched only at clock start and at each wrap.
        if (!start_nx) begin
            jcnt_nx = '0;
            dcnt_nx = '0;
        end else if (!start_clk_cl) begin
            jcnt_nx = '0;
            jr_nx   = eff_ratio(jbus_ratio);
            dcnt_nx = '0;
            dr_nx   = eff_ratio(dram_ratio);
        end else begin
            if (jcnt == jr - 4'd1) begin
                jcnt_nx = '0;
                jr_nx   = eff_ratio(jbus_ratio);
            end else begin
                jcnt_nx = jcnt + 4'd1;
            end
            if (dcnt == dr - 4'd1) begin
                dcnt_nx = '0;
                dr_nx   = eff_ratio(dram_ratio);
            end else begin
                dcnt_nx = dcnt + 4'd1;
            end
        end

        jtx_nx = start_nx && (jcnt_nx == jr_nx - 4'd1);
        dtx_nx = start_nx && (dcnt_nx == dr_nx - 4'd1);
        jrx_nx = start_nx && start_clk_cl && (jcnt_nx == 4'd0);
        drx_nx = start_nx && start_clk_cl && (dcnt_nx == 4'd0);
    end

    always_ff @(posedge cmp_gclk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            state               <= IDLE;
            cnt                 <= '0;
            idx                 <= '0;
            dbg_cnt             <= '0;
            jcnt                <= '0;
            jr                  <= 4'd2;
            dcnt                <= '0;
            dr                  <= 4'd2;
            start_clk_cl        <= 1'b0;
            cmp_grst_cl_l       <= 1'b0;
            cmp_dbginit_cl_l    <= 1'b0;
            cken_cg             <= '0;
            seq_done            <= 1'b0;
            ctu_jbus_tx_sync_cl <= 1'b0;
            ctu_jbus_rx_sync_cl <= 1'b0;
            ctu_dram_tx_sync_cl <= 1'b0;
            ctu_dram_rx_sync_cl <= 1'b0;
        end else begin
            state               <= state_nx;
            cnt                 <= cnt_nx;
            idx                 <= idx_nx;
            dbg_cnt             <= dbg_cnt_nx;
            jcnt                <= jcnt_nx;
            jr                  <= jr_nx;
            dcnt                <= dcnt_nx;
            dr                  <= dr_nx;
            start_clk_cl        <= start_nx;
            cmp_grst_cl_l       <= grst_nx;
            cmp_dbginit_cl_l    <= dbg_nx;
            cken_cg             <= cken_nx;
            seq_done            <= done_nx;
            ctu_jbus_tx_sync_cl <= jtx_nx;
            ctu_jbus_rx_sync_cl <= jrx_nx;
            ctu_dram_tx_sync_cl <= dtx_nx;
            ctu_dram_rx_sync_cl <= drx_nx;
        end
    end

endmodule

// File: tb/tb_ctu_clsp_cmpgen.sv
// Bench for ctu_clsp_cmpgen: a timeline model indexed by cycles since clock
// start, checked every cycle, plus literal checkpoints on the sequence timing.
module tb_ctu_clsp_cmpgen;

    localparam int G       = 4;
    localparam int RD      = 16;
    localparam int DL      = 8;
    localparam int SEQ_END = 22 * G;
    localparam int RUN_T   = SEQ_END + RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [21:0] mask = '0;
    logic [3:0]  jbus_ratio = 4'd4;
    logic [3:0]  dram_ratio = 4'd0;
    logic        req = 1'b0;
    logic        start_clk_cl, cmp_grst_cl_l, cmp_dbginit_cl_l, seq_done;
    logic        jtx, jrx, dtx, drx;
    logic [21:0] cken_cg;

    int total = 0;
    int bad = 0;

    ctu_clsp_cmpgen dut (
        .cmp_gclk            (clk),
        .io_pwron_rst_l      (rst_n),
        .clk_seq_go          (go),
        .cken_en_mask        (mask),
        .jbus_ratio          (jbus_ratio),
        .dram_ratio          (dram_ratio),
        .dbginit_req         (req),
        .start_clk_cl        (start_clk_cl),
        .cmp_grst_cl_l       (cmp_grst_cl_l),
        .cmp_dbginit_cl_l    (cmp_dbginit_cl_l),
        .ctu_jbus_tx_sync_cl (jtx),
        .ctu_jbus_rx_sync_cl (jrx),
        .ctu_dram_tx_sync_cl (dtx),
        .ctu_dram_rx_sync_cl (drx),
        .cken_cg             (cken_cg),
        .seq_done            (seq_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_run = 1'b0;
    int          t = 0;
    logic [21:0] m_cken = '0;
    int          dbg_left = 0;
    int          j_r = 2, j_p = 0, d_r = 2, d_p = 0;

    function automatic int eff(input logic [3:0] r);
        return (r < 4'd2) ? 2 : int'(r);
    endfunction

    task automatic m_idle();
        m_run = 1'b0; t = 0; m_cken = '0; dbg_left = 0; j_p = 0; d_p = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle();
        end else if (!m_run) begin
            if (go) begin
                m_run = 1'b1; t = 0; m_cken = '0; dbg_left = 0;
                j_r = eff(jbus_ratio); j_p = 0;
                d_r = eff(dram_ratio); d_p = 0;
            end
        end else if (!go) begin
            m_idle();
        end else begin
            t++;
            if (t >= G && t <= SEQ_END && (t % G) == 0) m_cken[t / G - 1] = mask[t / G - 1];
            if (t - 1 >= RUN_T) begin
                m_cken = mask;
                if (dbg_left > 0) dbg_left--;
                else if (req) dbg_left = DL;
            end
            if (j_p == j_r - 1) begin j_p = 0; j_r = eff(jbus_ratio); end else j_p++;
            if (d_p == d_r - 1) begin d_p = 0; d_r = eff(dram_ratio); end else d_p++;
        end
    end

    always @(negedge clk) begin
        logic e_grst;
        e_grst = m_run && (t >= RUN_T);
        chk("start_clk", start_clk_cl, m_run);
        chk("grst_l", cmp_grst_cl_l, e_grst);
        chk("seq_done", seq_done, e_grst);
        chk("dbginit_l", cmp_dbginit_cl_l, e_grst && dbg_left == 0);
        chk("cken", cken_cg, m_run ? m_cken : 22'h0);
        chk("jbus_tx", jtx, m_run && j_p == j_r - 1);
        chk("jbus_rx", jrx, m_run && j_p == 0 && t > 0);
        chk("dram_tx", dtx, m_run && d_p == d_r - 1);
        chk("dram_rx", drx, m_run && d_p == 0 && t > 0);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_start();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (start_clk_cl) break;
        end
        chk("start_rise", start_clk_cl, 1'b1);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_outs"}, {start_clk_cl, cmp_grst_cl_l, cmp_dbginit_cl_l, seq_done,
                             jtx, jrx, dtx, drx}, 8'h0);
        chk({tag, "_cken"}, cken_cg, 22'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        all_zero("idle");

        // Full sequence, all units enabled, jbus R=4, dram R=2.
        mask = 22'h3FFFFF; jbus_ratio = 4'd4; dram_ratio = 4'd0; go = 1'b1;
        wait_start();
        chk("t0_sync", {jtx, jrx, dtx, drx}, 4'b0000);
        chk("t0_cken", cken_cg, 22'h0);
        for (int k = 1; k <= RUN_T; k++) begin
            @(negedge clk);
            if (k == 1) chk("t1_dram", {dtx, drx}, 2'b10);
            if (k == 2) chk("t2_dram", {dtx, drx}, 2'b01);
            if (k == 3) chk("t3_lit", {jtx, jrx, 22'(cken_cg)}, {2'b10, 22'h0});
            if (k == 4) chk("t4_lit", {jtx, jrx, 22'(cken_cg)}, {2'b01, 22'h1});
            if (k == 87) chk("t87_cken", cken_cg, 22'h1FFFFF);
            if (k == 88) chk("t88_cken", cken_cg, 22'h3FFFFF);
            if (k == 103) chk("t103_grst", {cmp_grst_cl_l, seq_done}, 2'b00);
            if (k == 104) chk("t104_run", {cmp_grst_cl_l, seq_done, cmp_dbginit_cl_l}, 3'b111);
        end

        // Debug-init request at cycles 0 and 3; second lands inside the pulse.
        req = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            req = (j == 3);
            chk("dbg_pulse", cmp_dbginit_cl_l, j > DL);
        end
        req = 1'b0;

        // Asynchronous reset in RUN.
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1; go = 1'b0;
        repeat (3) @(negedge clk);

        // Only sparc0 enabled: reset release timing is unchanged.
        mask = 22'h000001; go = 1'b1;
        wait_start();
        for (int k = 1; k <= RUN_T; k++) begin
            @(negedge clk);
            if (k == SEQ_END) chk("m1_cken", cken_cg, 22'h1);
            if (k == RUN_T) chk("m1_grst", {cmp_grst_cl_l, 22'(cken_cg)}, {1'b1, 22'h1});
        end
        go = 1'b0;
        repeat (2) @(negedge clk);

        // Drop go just after idx 10 is enabled, then restart.
        mask = 22'h3FFFFF; go = 1'b1;
        wait_start();
        for (int k = 1; k <= 11 * G + 1; k++) @(negedge clk);
        chk("pre_drop_cken", cken_cg, 22'h7FF);
        go = 1'b0;
        @(negedge clk);
        all_zero("go_drop");
        go = 1'b1;
        wait_start();
        for (int k = 1; k <= G; k++) @(negedge clk);
        chk("restart_cken", cken_cg, 22'h1);

        // Randomized: ratios, masks, requests and go drops all move.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if ($urandom_range(5) == 0) jbus_ratio = 4'($urandom_range(15));
                if ($urandom_range(5) == 0) dram_ratio = 4'($urandom_range(15));
                if ($urandom_range(19) == 0) mask = 22'($urandom);
                req = ($urandom_range(5) == 0);
                if (go && $urandom_range(249) == 0) go = 1'b0;
                else if (!go && $urandom_range(3) == 0) go = 1'b1;
            end
            go = 1'b0;
            @(negedge clk);
            go = 1'b1;
        end
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
